// File: rtl/vcp_pkg.sv
// Shared definitions for the UART vector-load path (concatenator + load controller).
package vcp_pkg;

   localparam int          VCP_DATA_W    = 10;
   localparam int          VCP_ADDR_W    = 10;
   localparam int          VCP_DEPTH     = 1024;
   localparam logic [7:0]  VCP_CMD_SEL_A = 8'h01;
   localparam logic [7:0]  VCP_CMD_SEL_B = 8'h02;
   // High byte that marks end of a vector stream; the concatenator keys on it.
   localparam logic [7:0]  VCP_END_MARK  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FINISH = 2'd2
   } vlc_state_t;

endpackage

// File: rtl/vector_load_ctrl.sv
// Vector load controller: decodes the BRAM-select command, writes incoming
// words into BRAM A or B at an incrementing address, reports length on end.
// Optional idle-word watchdog enabled by defining VLC_TIMEOUT_EN.
module vector_load_ctrl
   import vcp_pkg::*;
#(
   parameter int          DATA_W         = VCP_DATA_W,
   parameter int          ADDR_W         = VCP_ADDR_W,
   parameter int          DEPTH          = VCP_DEPTH,
   parameter logic [7:0]  CMD_SEL_A      = VCP_CMD_SEL_A,
   parameter logic [7:0]  CMD_SEL_B      = VCP_CMD_SEL_B,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   input  logic [DATA_W-1:0] data_in,
   input  logic              flag_data_ready,
   input  logic              flag_end_write,
   output logic              flag_bram,
   output logic              bram_a_we,
   output logic              bram_b_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   output logic              load_done,
   output logic              load_sel,
   output logic [ADDR_W:0]   vec_len,
`ifdef VLC_TIMEOUT_EN
   output logic              load_error,
`endif
   output logic              overflow
);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] LOAD   = ST_LOAD;
   localparam logic [1:0] FINISH = ST_FINISH;

   // Address counter is one bit wider than the BRAM address so it can hold DEPTH.
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   logic [1:0]      state;
   logic            sel;
   logic [ADDR_W:0] addr;

`ifdef VLC_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;
   logic [31:0] to_cnt;
`endif

   wire is_cmd = rx_ready && (rx_data == CMD_SEL_A || rx_data == CMD_SEL_B);

   // Load FSM, address counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sel        <= 1'b0;
         addr       <= '0;
         flag_bram  <= 1'b0;
         bram_a_we  <= 1'b0;
         bram_b_we  <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         load_done  <= 1'b0;
         load_sel   <= 1'b0;
         vec_len    <= '0;
         overflow   <= 1'b0;
`ifdef VLC_TIMEOUT_EN
         load_error <= 1'b0;
         to_cnt     <= '0;
`endif
      end else begin
         // Strobes default low; only the branches below raise them.
         bram_a_we <= 1'b0;
         bram_b_we <= 1'b0;
         load_done <= 1'b0;
`ifdef VLC_TIMEOUT_EN
         load_error <= 1'b0;
`endif
         case (state)
            IDLE: begin
               flag_bram <= 1'b0;
               if (is_cmd) begin
                  // flag_bram rises next cycle, so the command byte never pairs.
                  sel       <= (rx_data == CMD_SEL_B);
                  addr      <= '0;
                  overflow  <= 1'b0;
                  flag_bram <= 1'b1;
                  state     <= LOAD;
`ifdef VLC_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end
            LOAD: begin
`ifdef VLC_TIMEOUT_EN
               to_cnt <= to_cnt + 32'd1;
`endif
               if (flag_data_ready) begin
`ifdef VLC_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  if (addr < DEPTH_L) begin
                     bram_a_we  <= ~sel;
                     bram_b_we  <= sel;
                     bram_addr  <= addr[ADDR_W-1:0];
                     bram_wdata <= data_in;
                     addr       <= addr + 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               // End marker wins over the watchdog; a word in the same cycle is kept.
               if (flag_end_write) begin
                  flag_bram <= 1'b0;
                  state     <= FINISH;
               end
`ifdef VLC_TIMEOUT_EN
               else if (!flag_data_ready && to_cnt == TO_LAST) begin
                  flag_bram  <= 1'b0;
                  load_error <= 1'b1;
                  state      <= IDLE;
               end
`endif
            end
            FINISH: begin
               flag_bram <= 1'b0;
               vec_len   <= addr;
               load_sel  <= sel;
               load_done <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               flag_bram <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_load_ctrl.sv
// Directed bench for vector_load_ctrl: one default-depth and one DEPTH=4 instance
// share the stimulus; writes are logged on the falling edge and checked in line.
module tb_vector_load_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, rx_ready, flag_data_ready, flag_end_write;
   logic [7:0] rx_data;
   logic [9:0] data_in;

   logic        fb, a_we, b_we, done, lsel, ovf;
   logic [9:0]  addr, wdata;
   logic [10:0] vlen;
   logic        fb4, a_we4, b_we4, done4, lsel4, ovf4;
   logic [9:0]  addr4, wdata4;
   logic [10:0] vlen4;
`ifdef VLC_TIMEOUT_EN
   logic lerr, lerr4;
`endif

   vector_load_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
      .data_in(data_in), .flag_data_ready(flag_data_ready), .flag_end_write(flag_end_write),
      .flag_bram(fb), .bram_a_we(a_we), .bram_b_we(b_we), .bram_addr(addr),
      .bram_wdata(wdata), .load_done(done), .load_sel(lsel), .vec_len(vlen),
`ifdef VLC_TIMEOUT_EN
      .load_error(lerr),
`endif
      .overflow(ovf));

   vector_load_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(100)) dut4 (
      .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
      .data_in(data_in), .flag_data_ready(flag_data_ready), .flag_end_write(flag_end_write),
      .flag_bram(fb4), .bram_a_we(a_we4), .bram_b_we(b_we4), .bram_addr(addr4),
      .bram_wdata(wdata4), .load_done(done4), .load_sel(lsel4), .vec_len(vlen4),
`ifdef VLC_TIMEOUT_EN
      .load_error(lerr4),
`endif
      .overflow(ovf4));

   typedef struct packed {
      logic       b;
      logic [9:0] addr;
      logic [9:0] data;
   } wr_t;

   wr_t log0[$];
   wr_t log4[$];
   int  both_we  = 0;
   int  done_cnt = 0;
   int  checks   = 0;
   int  errors   = 0;

   // Write/done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if ((a_we && b_we) || (a_we4 && b_we4)) both_we++;
      if (a_we || b_we)   log0.push_back('{b: b_we,  addr: addr,  data: wdata});
      if (a_we4 || b_we4) log4.push_back('{b: b_we4, addr: addr4, data: wdata4});
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      rx_ready = 1'b1; rx_data = b;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic send_word(input logic [9:0] d);
      flag_data_ready = 1'b1; data_in = d;
      tick();
      flag_data_ready = 1'b0;
   endtask

   // End pulse, then one FINISH cycle; returns where load_done/vec_len are valid.
   task automatic end_load();
      flag_end_write = 1'b1;
      tick();
      flag_end_write = 1'b0;
      tick();
   endtask

   int          k;
   logic [10:0] saved_len;
   int          saved_done;

   initial begin
      reset = 1'b1; rx_ready = 1'b0; rx_data = '0; data_in = '0;
      flag_data_ready = 1'b0; flag_end_write = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_outs", {fb, a_we, b_we, done, lsel, ovf}, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_vlen", vlen, 32'h0);
`ifdef VLC_TIMEOUT_EN
      chk("rst_lerr", lerr, 32'h0);
`endif
      reset = 1'b0;
      tick();
      log0.delete(); log4.delete();

      // Select A, three words
      send_cmd(8'h01);
      chk("t1_fb_open", fb, 32'h1);
      send_word(10'h123); send_word(10'h0AB); send_word(10'h3FF);
      flag_end_write = 1'b1; tick(); flag_end_write = 1'b0;
      chk("t1_fb_finish", fb, 32'h0);
      tick();
      chk("t1_done", done, 32'h1);
      chk("t1_vlen", vlen, 32'd3);
      chk("t1_lsel", lsel, 32'h0);
      tick();
      chk("t1_done_pulse", done, 32'h0);
      chk("t1_nwr", log0.size(), 32'd3);
      chk("t1_w0", log0[0], {1'b0, 10'd0, 10'h123});
      chk("t1_w1", log0[1], {1'b0, 10'd1, 10'h0AB});
      chk("t1_w2", log0[2], {1'b0, 10'd2, 10'h3FF});

      // Invalid command then B
      log0.delete(); log4.delete();
      send_cmd(8'h07);
      chk("t2_bad_cmd", fb, 32'h0);
      tick();
      chk("t2_bad_cmd2", fb, 32'h0);
      send_cmd(8'h02);
      chk("t2_fb_open", fb, 32'h1);
      send_word(10'h055); send_word(10'h2AA);
      end_load();
      chk("t2_done", done, 32'h1);
      chk("t2_vlen", vlen, 32'd2);
      chk("t2_lsel", lsel, 32'h1);
      chk("t2_nwr", log0.size(), 32'd2);
      chk("t2_w0", log0[0], {1'b1, 10'd0, 10'h055});
      chk("t2_w1", log0[1], {1'b1, 10'd1, 10'h2AA});

      // Overflow on the DEPTH=4 instance
      log0.delete(); log4.delete();
      send_cmd(8'h01);
      for (int i = 1; i <= 6; i++) send_word(10'(i));
      chk("t3_ovf4", ovf4, 32'h1);
      chk("t3_ovf_big", ovf, 32'h0);
      end_load();
      chk("t3_done4", done4, 32'h1);
      chk("t3_vlen4", vlen4, 32'd4);
      chk("t3_vlen_big", vlen, 32'd6);
      chk("t3_ovf4_sticky", ovf4, 32'h1);
      chk("t3_nwr4", log4.size(), 32'd4);
      chk("t3_w0", log4[0], {1'b0, 10'd0, 10'd1});
      chk("t3_w3", log4[3], {1'b0, 10'd3, 10'd4});
      send_cmd(8'h02);
      chk("t3_ovf4_clr", ovf4, 32'h0);
      send_word(10'h011);
      end_load();
      chk("t3_vlen4_next", vlen4, 32'd1);
      chk("t3_lsel4", lsel4, 32'h1);

      // Empty load
      log0.delete(); log4.delete();
      send_cmd(8'h01);
      end_load();
      chk("t4_done", done, 32'h1);
      chk("t4_vlen0", vlen, 32'd0);
      chk("t4_lsel", lsel, 32'h0);
      tick();
      chk("t4_nwr", log0.size(), 32'd0);

      // Word and end marker in the same cycle
      send_cmd(8'h01);
      send_word(10'h010); send_word(10'h020);
      flag_data_ready = 1'b1; flag_end_write = 1'b1; data_in = 10'h030;
      tick();
      flag_data_ready = 1'b0; flag_end_write = 1'b0;
      tick();
      chk("t4_sim_done", done, 32'h1);
      chk("t4_sim_vlen", vlen, 32'd3);
      chk("t4_sim_nwr", log0.size(), 32'd3);
      chk("t4_sim_w2", log0[2], {1'b0, 10'd2, 10'h030});

      // End marker while idle is ignored
      tick();
      flag_end_write = 1'b1; tick(); flag_end_write = 1'b0;
      tick(); tick();
      chk("t4_idle_end", {fb, done}, 32'h0);

      // Reset mid-load
      log0.delete(); log4.delete();
      send_cmd(8'h01);
      send_word(10'h077); send_word(10'h078);
      reset = 1'b1;
      tick();
      chk("t5_rst_outs", {fb, a_we, b_we, done, lsel, ovf}, 32'h0);
      chk("t5_rst_addr", addr, 32'h0);
      chk("t5_rst_vlen", vlen, 32'h0);
      reset = 1'b0;
      tick();
      log0.delete(); log4.delete();
      send_cmd(8'h01);
      send_word(10'h099);
      end_load();
      chk("t5_restart_w", log0[0], {1'b0, 10'd0, 10'h099});
      chk("t5_restart_vlen", vlen, 32'd1);

`ifdef VLC_TIMEOUT_EN
      // Watchdog abort
      tick();
      saved_len  = vlen;
      saved_done = done_cnt;
      send_cmd(8'h01);
      send_word(10'h005);
      k = 0;
      while (lerr !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      chk("t6_to_cycles", k, 32'd100);
      chk("t6_fb_drop", fb, 32'h0);
      chk("t6_vlen_kept", vlen, saved_len);
      tick();
      chk("t6_lerr_pulse", lerr, 32'h0);
      chk("t6_no_done", done_cnt, saved_done);
`endif

      chk("we_exclusive", both_we, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_load_ctrl.md
Name: vector_load_ctrl

Overview:
- Downstream stage of the UART byte-pair concatenator; owns the "load vector into BRAM" transaction.
- Decodes a one-byte BRAM-select command from the UART receiver and raises flag_bram so the concatenator starts pairing bytes.
- Writes each 10-bit word into the selected vector BRAM (A or B) at an incrementing address.
- On the end-of-write marker, closes the transaction, reports the vector length and pulses done.

Parameters:
- DATA_W, 10, width of one vector element (matches the concatenator's data_out).
- ADDR_W, 10, BRAM address width.
- DEPTH, 1024, words per BRAM; must be at most 2**ADDR_W.
- CMD_SEL_A, 8'h01, command byte selecting BRAM A.
- CMD_SEL_B, 8'h02, command byte selecting BRAM B.
- TIMEOUT_CYCLES, 50_000_000, idle-word watchdog limit; used only with VLC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; the block's single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_ready  in  1  single-cycle pulse from the UART receiver: rx_data is valid.
- rx_data  in  8  received byte.
- data_in  in  DATA_W  concatenated word from the concatenator.
- flag_data_ready  in  1  single-cycle pulse: data_in is valid.
- flag_end_write  in  1  single-cycle pulse: end marker (high byte 8'hFF) received.
- flag_bram  out  1  high while a load is open; drives the concatenator's flag_bram.
- bram_a_we  out  1  write enable, BRAM A.
- bram_b_we  out  1  write enable, BRAM B.
- bram_addr  out  ADDR_W  write address, shared by both BRAMs.
- bram_wdata  out  DATA_W  write data, shared by both BRAMs.
- load_done  out  1  single-cycle pulse when a load completes.
- load_sel  out  1  BRAM of the last completed load: 0 = A, 1 = B.
- vec_len  out  ADDR_W+1  words stored by the last completed load.
- overflow  out  1  sticky: the current or last load received more than DEPTH words.
- load_error  out  1  single-cycle pulse when a load is aborted; exists only with VLC_TIMEOUT_EN.

Behaviour:
- Reset: state IDLE; every output 0, including vec_len, load_sel and overflow; address counter 0.
- All outputs are registered.

State machine IDLE -> LOAD -> FINISH -> IDLE.
- IDLE:
  - flag_bram = 0.
  - On rx_ready with rx_data == CMD_SEL_A or CMD_SEL_B: latch sel (A = 0, B = 1), clear addr and overflow, go to LOAD.
  - Any other byte is ignored and the block stays in IDLE.
  - flag_bram rises the cycle after the command byte, so the command byte never reaches the concatenator.
- LOAD:
  - flag_bram = 1.
  - On flag_data_ready with addr < DEPTH, in the next cycle:
    - the selected we is high for exactly one cycle;
    - bram_addr = addr and bram_wdata = the data_in captured at the pulse;
    - addr increments.
  - Write latency: 1 cycle from flag_data_ready.
  - On flag_data_ready with addr == DEPTH: no write, addr holds, overflow <= 1.
  - rx_ready and rx_data are ignored in LOAD.
  - On flag_end_write: go to FINISH.
- Simultaneous flag_data_ready and flag_end_write: the word is written, is counted in vec_len, then the block goes to FINISH.
- FINISH (one cycle):
  - flag_bram = 0.
  - vec_len <= addr (0 allowed) and load_sel <= sel.
  - load_done pulses on the following cycle, aligned with vec_len becoming valid.
  - Next state: IDLE.
- flag_end_write while in IDLE is ignored.
- Write enables are mutually exclusive and never both high.
- When no write is in progress, bram_addr and bram_wdata hold their last values.
- Reset mid-load (any state): immediate return to IDLE next cycle.
  - Any pending write is dropped; flag_bram drops.
  - Partial data already in the BRAM is not cleared.

Optional Feature:
- Macro: VLC_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to LOAD and on every flag_data_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 while in LOAD, the block aborts to IDLE.
  - On abort: flag_bram drops, load_error pulses for one cycle, vec_len and load_sel are unchanged, and load_done does not pulse.
- Without the macro: no counter and no load_error port; LOAD waits indefinitely.

Decomposition:
- Shared package vcp_pkg holds:
  - the state enum type;
  - the command byte constants CMD_SEL_A and CMD_SEL_B;
  - DATA_W, ADDR_W and DEPTH defaults;
  - the end-marker constant 8'hFF, shared with the concatenator.
- No sub-module: one FSM plus an address counter; the watchdog is inline under the macro.

Test Plan:
- Select A and stream three words:
  - Stimulus: rx byte 8'h01, then flag_data_ready with data_in 10'h123, 10'h0AB, 10'h3FF, then flag_end_write.
  - Required: bram_a_we pulses at addr 0, 1, 2 with that data; bram_b_we never asserts; load_done pulses; vec_len = 3; load_sel = 0; flag_bram is low again.
- Invalid command:
  - Stimulus: rx byte 8'h07, then rx byte 8'h02.
  - Required: the first byte leaves flag_bram low; the second opens a B load, and its writes use bram_b_we starting at addr 0.
- Overflow (DEPTH = 4 override):
  - Stimulus: 6 words, then flag_end_write.
  - Required: exactly 4 writes at addr 0-3; overflow = 1; vec_len = 4.
  - Then a new select clears overflow.
- Empty load and simultaneous event:
  - Stimulus: select A, then immediate flag_end_write.
  - Required: vec_len = 0, load_done pulses, no write enables.
  - Stimulus: flag_data_ready and flag_end_write in the same cycle after 2 words.
  - Required: 3 writes and vec_len = 3.
- Reset mid-load:
  - Stimulus: assert reset in the cycle after a flag_data_ready.
  - Required: no write enable next cycle; all outputs 0; a later select 8'h01 restarts at addr 0.
- VLC_TIMEOUT_EN (TIMEOUT_CYCLES = 100):
  - Stimulus: select A, one word, then silence.
  - Required: load_error pulses 100 cycles after the word; flag_bram drops; no load_done; vec_len unchanged.
